tdc_seq: RTL and testbench

Measurement sequencer for the TDC slice. Arms the TDC and issues one pulse-generator toggle per sample. After a fixed settle time it samples the pop-count Hamming weight and accumulates sum/min/max over a programmable number of samples. It returns the result over a valid/ready handshake. It sits between the host/scan interface and the TDC datapath enable and toggle inputs. In sequenced operation the launch and capture clocks are the same clock.

---
 rtl/tdc_seq_if.sv | 12 +
 rtl/tdc_seq.sv | 93 +++++++++
 tb/tb_tdc_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tdc_seq_if.sv
// tdc_seq_if: host/result handshake and TDC datapath signals of the measurement sequencer.
interface tdc_seq_if #(parameter int N = 64, parameter int SW = 16);
  localparam int HWW = $clog2(N) + 1;
  logic start, abort, res_ready, tdc_en, pg_tog, busy, res_valid;
  logic [SW-1:0] n_samples, samples_done;
  logic [HWW-1:0] hw, hw_min, hw_max;
  logic [SW+HWW-1:0] hw_sum;
  modport master(output start, abort, n_samples, res_ready, hw,
                 input tdc_en, pg_tog, busy, res_valid, hw_sum, hw_min, hw_max, samples_done);
  modport slave(input start, abort, n_samples, res_ready, hw,
                output tdc_en, pg_tog, busy, res_valid, hw_sum, hw_min, hw_max, samples_done);
endinterface

// File: rtl/tdc_seq.sv
// tdc_seq: TDC measurement sequencer accumulating Hamming-weight sum/min/max over n samples.
// Define TDC_SEQ_MINMAX_EN to build min/max tracking; otherwise hw_min/hw_max are tied to 0.
module tdc_seq #(
  parameter int N = 64,
  parameter int SETTLE = 3,
  parameter int SW = 16
) (
  input logic clk,
  input logic rst,
  tdc_seq_if.slave s
);
  localparam int HWW = $clog2(N) + 1;
  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] ARM_T = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WAIT_T = TW'(SETTLE > 1 ? SETTLE - 2 : 0);
  typedef enum logic [2:0] {IDLE, ARM, LAUNCH, WAIT, SAMPLE, DONE} state_t;
  state_t st, nxt;
  logic [TW-1:0] tmr;
  logic [SW-1:0] rem;
  logic tdc_en_d, pg_tog_d, busy_d, res_valid_d, go, samp;
  assign go = (st == IDLE) && (nxt == ARM);
  assign samp = (st == SAMPLE) && !s.abort;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      tmr <= '0;
    end else begin
      st <= nxt;
      tmr <= (nxt != st) ? ((nxt == ARM) ? ARM_T : WAIT_T) : tmr - TW'(1);
    end
  end
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = (s.start && !s.abort && s.n_samples != '0) ? ARM : IDLE;
      ARM:     nxt = s.abort ? IDLE : (tmr == '0 ? LAUNCH : ARM);
      LAUNCH:  nxt = s.abort ? IDLE : (SETTLE == 1 ? SAMPLE : WAIT);
      WAIT:    nxt = s.abort ? IDLE : (tmr == '0 ? SAMPLE : WAIT);
      SAMPLE:  nxt = s.abort ? IDLE : (rem > SW'(1) ? LAUNCH : DONE);
      DONE:    nxt = s.res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    tdc_en_d = nxt inside {ARM, LAUNCH, WAIT, SAMPLE};
    pg_tog_d = nxt == LAUNCH;
    busy_d = nxt != IDLE;
    res_valid_d = nxt == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s.tdc_en <= 1'b0;
      s.pg_tog <= 1'b0;
      s.busy <= 1'b0;
      s.res_valid <= 1'b0;
      s.hw_sum <= '0;
      s.samples_done <= '0;
      rem <= '0;
    end else begin
      s.tdc_en <= tdc_en_d;
      s.pg_tog <= pg_tog_d;
      s.busy <= busy_d;
      s.res_valid <= res_valid_d;
      if (go) begin
        rem <= s.n_samples;
        s.hw_sum <= '0;
        s.samples_done <= '0;
      end else if (samp) begin
        rem <= rem - SW'(1);
        s.hw_sum <= s.hw_sum + (SW + HWW)'(s.hw);
        s.samples_done <= s.samples_done + SW'(1);
      end
    end
  end
`ifdef TDC_SEQ_MINMAX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s.hw_min <= '0;
      s.hw_max <= '0;
    end else if (go) begin
      s.hw_min <= '1;
      s.hw_max <= '0;
    end else if (samp) begin
      if (s.hw < s.hw_min) s.hw_min <= s.hw;
      if (s.hw > s.hw_max) s.hw_max <= s.hw;
    end
  end
`else
  assign s.hw_min = '0;
  assign s.hw_max = '0;
`endif
endmodule

// File: tb/tb_tdc_seq.sv
// tb_tdc_seq: directed self-checking bench for tdc_seq.
module tb_tdc_seq;
  localparam int S = 3;
  localparam int HWW = 7;
`ifdef TDC_SEQ_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tdc_seq_if #(.N(64), .SW(16)) s ();
  tdc_seq #(.N(64), .SETTLE(S), .SW(16)) dut (.clk(clk), .rst(rst), .s(s));
  int n_chk = 0;
  int n_fail = 0;
  logic [HWW-1:0] sv [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs from IDLE until the first res_valid cycle; hw carries sv[k] only in SAMPLE cycles.
  task automatic run(input int n, output int lat, output int pg_err);
    int k;
    lat = -1;
    pg_err = 0;
    for (int t = 0; t < 400; t++) begin
      k = (t - 1 - 2 * S) / (S + 1);
      if (t > 0 && s.pg_tog !== ((t >= 1 + S) && ((t - 1 - S) % (S + 1) == 0) && (t < 1 + S + n * (S + 1)))) pg_err++;
      if (s.res_valid === 1'b1) begin
        lat = t;
        break;
      end
      s.start = (t == 0);
      s.n_samples = 16'(n);
      s.hw = ((t >= 1 + 2 * S) && ((t - 1 - 2 * S) % (S + 1) == 0) && k < n) ? sv[k] : 7'd63;
      step();
    end
    s.start = 1'b0;
    s.hw = 7'd63;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s.start = 0; s.abort = 0; s.res_ready = 0; s.hw = 7'd63; s.n_samples = '0;
    step(); step();
    n_chk++; if ({s.busy, s.tdc_en, s.pg_tog, s.res_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {s.busy, s.tdc_en, s.pg_tog, s.res_valid}); end
    n_chk++; if (s.hw_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", s.hw_sum); end
    n_chk++; if (s.samples_done !== '0) begin n_fail++; $display("FAIL reset_done: got %0d expected 0", s.samples_done); end
    n_chk++; if ({s.hw_min, s.hw_max} !== '0) begin n_fail++; $display("FAIL reset_minmax: got %0d/%0d expected 0/0", s.hw_min, s.hw_max); end
    rst = 1'b0;
    step();
  endtask

  task automatic accept(input string nm);
    s.res_ready = 1'b1;
    step();
    s.res_ready = 1'b0;
    n_chk++; if ({s.res_valid, s.busy} !== 2'b00) begin n_fail++; $display("FAIL %s_accept: valid/busy got %b expected 00", nm, {s.res_valid, s.busy}); end
  endtask

  task automatic test_basic();
    int lat, pe;
    sv[0] = 10; sv[1] = 20; sv[2] = 30; sv[3] = 40;
    run(4, lat, pe);
    n_chk++; if (lat != 1 + S + 4 * (S + 1)) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, 1 + S + 4 * (S + 1)); end
    n_chk++; if (pe != 0) begin n_fail++; $display("FAIL basic_pg_tog: got %0d bad cycles expected 0", pe); end
    n_chk++; if (s.hw_sum !== 23'd100) begin n_fail++; $display("FAIL basic_sum: got %0d expected 100", s.hw_sum); end
    n_chk++; if (s.hw_min !== (MM ? 7'd10 : 7'd0)) begin n_fail++; $display("FAIL basic_min: got %0d expected %0d", s.hw_min, MM ? 10 : 0); end
    n_chk++; if (s.hw_max !== (MM ? 7'd40 : 7'd0)) begin n_fail++; $display("FAIL basic_max: got %0d expected %0d", s.hw_max, MM ? 40 : 0); end
    n_chk++; if (s.samples_done !== 16'd4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", s.samples_done); end
    n_chk++; if ({s.busy, s.tdc_en} !== 2'b10) begin n_fail++; $display("FAIL basic_done_state: busy/tdc_en got %b expected 10", {s.busy, s.tdc_en}); end
    accept("basic");
  endtask

  task automatic test_back_to_back_backpressure();
    int lat, pe, bad;
    sv[0] = 5; sv[1] = 9;
    run(2, lat, pe);
    n_chk++; if (lat != 1 + S + 2 * (S + 1)) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, 1 + S + 2 * (S + 1)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      s.start = i[0]; s.abort = ~i[0]; s.n_samples = 16'd3;
      step();
      if (s.res_valid !== 1'b1 || s.hw_sum !== 23'd14 || s.samples_done !== 16'd2 || s.busy !== 1'b1 || s.tdc_en !== 1'b0) bad++;
    end
    s.start = 0; s.abort = 0;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    accept("bp");
    step(); step();
    n_chk++; if (s.busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_restart: busy got %b expected 0", s.busy); end
  endtask

  task automatic test_abort();
    int bad;
    s.n_samples = 16'd4; s.start = 1'b1;
    step();
    s.start = 1'b0;
    for (int i = 0; i < S + 1; i++) step();
    n_chk++; if ({s.busy, s.tdc_en, s.pg_tog} !== 3'b110) begin n_fail++; $display("FAIL abort_in_wait: busy/tdc_en/pg got %b expected 110", {s.busy, s.tdc_en, s.pg_tog}); end
    s.abort = 1'b1;
    step();
    s.abort = 1'b0;
    n_chk++; if ({s.busy, s.tdc_en, s.pg_tog, s.res_valid} !== 4'b0) begin n_fail++; $display("FAIL abort_stop: got %b expected 0000", {s.busy, s.tdc_en, s.pg_tog, s.res_valid}); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s.res_valid !== 1'b0 || s.busy !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d bad cycles expected 0", bad); end
    s.start = 1'b1; s.abort = 1'b1;
    step();
    s.start = 1'b0; s.abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (s.busy !== 1'b0 || s.tdc_en !== 1'b0) bad++;
      step();
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL abort_start_idle: got %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_zero_single();
    int lat, pe, bad;
    s.n_samples = '0; s.start = 1'b1;
    step();
    s.start = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (s.busy !== 1'b0 || s.tdc_en !== 1'b0) bad++;
      step();
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL zero_ignored: got %0d busy cycles expected 0", bad); end
    sv[0] = 63;
    run(1, lat, pe);
    n_chk++; if (lat != 1 + S + (S + 1)) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, 1 + S + (S + 1)); end
    n_chk++; if (pe != 0) begin n_fail++; $display("FAIL single_pg_tog: got %0d bad cycles expected 0", pe); end
    n_chk++; if (s.hw_sum !== 23'd63) begin n_fail++; $display("FAIL single_sum: got %0d expected 63", s.hw_sum); end
    n_chk++; if ({s.hw_min, s.hw_max} !== (MM ? {7'd63, 7'd63} : 14'd0)) begin n_fail++; $display("FAIL single_minmax: got %0d/%0d expected %0d", s.hw_min, s.hw_max, MM ? 63 : 0); end
    n_chk++; if (s.samples_done !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", s.samples_done); end
    accept("single");
  endtask

  task automatic test_reset_midrun();
    int lat, pe;
    s.n_samples = 16'd4; s.start = 1'b1; s.hw = 7'd63;
    step();
    s.start = 1'b0;
    for (int i = 1; i < 1 + 2 * S + (S + 1); i++) step();
    n_chk++; if (s.hw_sum !== 23'd63) begin n_fail++; $display("FAIL midrun_partial: got %0d expected 63", s.hw_sum); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if ({s.busy, s.tdc_en, s.pg_tog, s.res_valid} !== 4'b0 || s.hw_sum !== '0 || s.samples_done !== '0 || {s.hw_min, s.hw_max} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: ctrl %b sum %0d count %0d min %0d max %0d expected all 0", {s.busy, s.tdc_en, s.pg_tog, s.res_valid}, s.hw_sum, s.samples_done, s.hw_min, s.hw_max);
    end
    step();
    sv[0] = 1; sv[1] = 2; sv[2] = 3; sv[3] = 50;
    run(4, lat, pe);
    n_chk++; if (lat != 1 + S + 4 * (S + 1)) begin n_fail++; $display("FAIL rerun_latency: got %0d expected %0d", lat, 1 + S + 4 * (S + 1)); end
    n_chk++; if (s.hw_sum !== 23'd56) begin n_fail++; $display("FAIL rerun_sum: got %0d expected 56", s.hw_sum); end
    n_chk++; if ({s.hw_min, s.hw_max} !== (MM ? {7'd1, 7'd50} : 14'd0)) begin n_fail++; $display("FAIL rerun_minmax: got %0d/%0d expected %0d/%0d", s.hw_min, s.hw_max, MM ? 1 : 0, MM ? 50 : 0); end
    n_chk++; if (s.samples_done !== 16'd4) begin n_fail++; $display("FAIL rerun_count: got %0d expected 4", s.samples_done); end
    accept("rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_backpressure();
    test_abort();
    test_zero_single();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
